// File: rtl/counter_ctrl.sv
// Start/stop/pause/load sequencer for a CNT_W-bit display counter, stepped by a prescaler tick.
// Commands take effect on the sampling edge, tick/done one cycle after a step, no backpressure.
module counter_ctrl #(
  parameter int PRE_W = 26,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  input  logic             dir,
  input  logic             auto_reload,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic             paused
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;

  logic [CNT_W-1:0] start_val;
  logic [CNT_W-1:0] next_cnt;
  logic             terminal;
  logic             start_ok;

  always_comb begin
    start_val = dir ? limit : '0;
    next_cnt  = dir ? (count_q - CNT_W'(1)) : (count_q + CNT_W'(1));
    terminal  = dir ? (count_q == '0) : (count_q == limit);
    // start is only a command where it can act; in RUN/HOLD it falls through
    start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    state_d = state_q;
    pre_d   = pre_q;
    count_d = count_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      pre_d   = '0;
    end else if (load) begin
      count_d = load_val;
      pre_d   = '0;
      if (state_q == S_DONE) state_d = S_IDLE;
    end else if (start_ok) begin
      state_d = S_RUN;
      pre_d   = '0;
      if (state_q == S_DONE) count_d = start_val;
    end else if (pause && (state_q == S_RUN)) begin
      state_d = S_HOLD;
    end else if (!pause && (state_q == S_HOLD)) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (pre_q == prescale) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (terminal) begin
          done_d = 1'b1;
          if (auto_reload) count_d = start_val;
          else             state_d = S_DONE;
        end else begin
          count_d = next_cnt;
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    busy_d   = (state_d == S_RUN) || (state_d == S_HOLD);
    paused_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      count_q  <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      count_q  <= count_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
    end
  end

  assign count  = count_q;
  assign tick   = tick_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: a behavioural model checked every cycle plus directed scenarios with literal expectations.
module tb_counter_ctrl;
  localparam int PRE_W = 26;
  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stop, pause, load, dir, auto_reload;
  logic [CNT_W-1:0] load_val, limit;
  logic [PRE_W-1:0] prescale;
  logic [CNT_W-1:0] count;
  logic             tick, done, busy, paused;

  int n_chk  = 0;
  int n_fail = 0;

  counter_ctrl #(.PRE_W(PRE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .load(load),
    .load_val(load_val), .limit(limit), .prescale(prescale), .dir(dir),
    .auto_reload(auto_reload), .count(count), .tick(tick), .done(done),
    .busy(busy), .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode name, cycles elapsed in the current period, count as an integer.
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mode_t;
  mode_t m_mode;
  int    m_phase, m_count;
  bit    m_tick, m_done;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = M_IDLE; m_phase = 0; m_count = 0; m_tick = 0; m_done = 0;
      end else begin
        m_tick = 0; m_done = 0;
        if (stop) begin
          m_mode = M_IDLE; m_phase = 0;
        end else if (load) begin
          m_count = int'(load_val); m_phase = 0;
          if (m_mode == M_DONE) m_mode = M_IDLE;
        end else if (start && (m_mode == M_IDLE || m_mode == M_DONE)) begin
          if (m_mode == M_DONE) m_count = dir ? int'(limit) : 0;
          m_mode = M_RUN; m_phase = 0;
        end else if (pause && m_mode == M_RUN) begin
          m_mode = M_HOLD;
        end else if (!pause && m_mode == M_HOLD) begin
          m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
          if (m_phase == int'(prescale)) begin
            m_phase = 0;
            m_tick  = 1;
            if (dir ? (m_count == 0) : (m_count == int'(limit))) begin
              m_done = 1;
              if (auto_reload) m_count = dir ? int'(limit) : 0;
              else             m_mode = M_DONE;
            end else begin
              m_count = dir ? (m_count + CMOD - 1) % CMOD : (m_count + 1) % CMOD;
            end
          end else begin
            m_phase++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_count",  count,  m_count);
      chk("model_tick",   tick,   int'(m_tick));
      chk("model_done",   done,   int'(m_done));
      chk("model_busy",   busy,   int'(m_mode == M_RUN || m_mode == M_HOLD));
      chk("model_paused", paused, int'(m_mode == M_HOLD));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!tick && n < maxc);
    if (!tick) chk("tick_timeout", tick, 1);
  endtask

  int exp1 [6] = '{1, 2, 3, 4, 5, 5};
  int exp2 [6] = '{1, 0, 2, 1, 0, 2};
  int dne2 [6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    int n;
    int hold_ticks;
    rst = 1'b0; start = 0; stop = 0; pause = 0; load = 0; dir = 0; auto_reload = 0;
    load_val = '0; limit = '0; prescale = '0;
    #1 rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("reset_count", count, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tick", tick, 0);
    chk("reset_done", done, 0);
    chk("reset_paused", paused, 0);

    // one-shot up count to 5, prescale 3
    prescale = 3; dir = 0; limit = 5; auto_reload = 0;
    start = 1; cyc(1); start = 0;
    chk("t1_busy_at_start", busy, 1);
    for (int i = 0; i < 6; i++) begin
      wait_tick(20, n);
      chk("t1_gap", n, 4);
      chk("t1_count", count, exp1[i]);
      chk("t1_done", done, int'(i == 5));
    end
    chk("t1_busy_done", busy, 0);
    cyc(1);
    chk("t1_hold_count", count, 5);
    chk("t1_no_tick", tick, 0);

    // auto-reload down count from a load of 2, prescale 0
    load_val = 2; load = 1; cyc(1); load = 0;
    chk("t2_load", count, 2);
    chk("t2_idle", busy, 0);
    dir = 1; limit = 2; prescale = 0; auto_reload = 1;
    start = 1; cyc(1); start = 0;
    for (int i = 0; i < 6; i++) begin
      wait_tick(5, n);
      chk("t2_gap", n, 1);
      chk("t2_count", count, exp2[i]);
      chk("t2_done", done, dne2[i]);
    end
    stop = 1; cyc(1); stop = 0;
    chk("t2_stop_count", count, 2);
    chk("t2_stop_tick", tick, 0);

    // pause for 10 cycles with the prescaler at 2 of 3
    dir = 0; limit = 15; prescale = 3; auto_reload = 1;
    start = 1; cyc(1); start = 0;
    cyc(2);
    pause = 1;
    hold_ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      hold_ticks += int'(tick);
      chk("t3_paused", paused, 1);
    end
    chk("t3_hold_ticks", hold_ticks, 0);
    pause = 0;
    cyc(1);
    chk("t3_release_paused", paused, 0);
    chk("t3_release_busy", busy, 1);
    wait_tick(20, n);
    chk("t3_after_release", n, 2);
    chk("t3_count", count, 3);

    // stop and start together during RUN
    stop = 1; start = 1; cyc(1); stop = 0; start = 0;
    chk("t4_busy", busy, 0);
    chk("t4_tick", tick, 0);
    chk("t4_count", count, 3);

    // load of 9 on a step edge with count 4
    load_val = 4; load = 1; cyc(1); load = 0;
    start = 1; cyc(1); start = 0;
    cyc(3);
    load_val = 9; load = 1; cyc(1); load = 0;
    chk("t5_count", count, 9);
    chk("t5_tick", tick, 0);
    chk("t5_busy", busy, 1);
    wait_tick(20, n);
    chk("t5_gap", n, 4);
    chk("t5_next", count, 10);

    // async reset between edges while running at count 7
    load_val = 7; load = 1; cyc(1); load = 0;
    chk("t6_pre", count, 7);
    #1 rst = 1'b1;
    #1;
    chk("t6_count", count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_tick", tick, 0);
    chk("t6_done", done, 0);
    chk("t6_paused", paused, 0);
    #3 rst = 1'b0;
    cyc(2);
    chk("t6_after_count", count, 0);
    chk("t6_after_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Programmable sequencer for the lab's 4-bit display counter. It replaces the derived slow clock with a single-clock prescaler that produces a clock-enable tick. It adds start/stop/pause/load control, up/down direction, a programmable terminal count, and one-shot or auto-reload operation. It sits between the board push-button/switch decode and the 7-segment/LED drivers, and everything runs in the `clk` domain.

## Interface
Parameters:
- `PRE_W`, 26: prescaler width in bits.
- `CNT_W`, 4: counter width in bits.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin or resume counting (see priority).
- `stop`  in  1  abort to IDLE; `count` holds its value.
- `pause`  in  1  level; while high, RUN freezes into HOLD.
- `load`  in  1  synchronous load of `load_val` into `count`.
- `load_val`  in  CNT_W  value loaded on `load`.
- `limit`  in  CNT_W  terminal value when counting up; reload value when counting down.
- `prescale`  in  PRE_W  tick period is `prescale`+1 clk cycles.
- `dir`  in  1  0 = up, 1 = down.
- `auto_reload`  in  1  1 = wrap and continue at terminal; 0 = stop in DONE.
- `count`  out  CNT_W  current count, registered.
- `tick`  out  1  one-cycle pulse, high in the cycle a new `count` is first visible.
- `done`  out  1  one-cycle pulse coincident with the terminal `tick`.
- `busy`  out  1  high in RUN or HOLD.
- `paused`  out  1  high in HOLD.

## Operation
- States:
  - IDLE: stopped; `count` holds its value.
  - RUN: prescaler counting.
  - HOLD: prescaler and `count` frozen.
  - DONE: terminal reached in one-shot mode.
- Reset: state IDLE, prescaler 0, `count` 0, and `tick`, `done`, `busy`, `paused` all 0.
- Command priority per cycle is stop > load > start > pause. Only the highest-priority asserted command acts in a given cycle.
- `stop`: state goes to IDLE from any state; prescaler clears to 0; `count` unchanged.
- `load`: `count` takes `load_val` and the prescaler clears to 0.
  - From DONE, state goes to IDLE.
  - In IDLE, RUN or HOLD, state is unchanged.
- `start`:
  - IDLE → RUN, counting from the current `count`.
  - DONE → RUN with `count` set to the start value (0 if `dir`=0, `limit` if `dir`=1).
  - Ignored in RUN and HOLD.
- `pause`: RUN → HOLD while `pause`=1; HOLD → RUN on the first cycle `pause`=0. The prescaler value is preserved across HOLD.
- Prescaler (RUN only):
  - Increments each cycle.
  - When it equals `prescale`, it clears to 0 and a count step occurs on that edge.
- Count step, terminal condition:
  - Up: terminal when `count`==`limit`.
  - Down: terminal when `count`==0.
- Count step, non-terminal: `count` becomes `count`±1, modulo 2^CNT_W. Counting up from above `limit` wraps through 0 to reach `limit`.
- Count step, terminal:
  - `auto_reload`=1: `count` takes the start value, `done` pulses, state stays RUN.
  - `auto_reload`=0: `count` holds the terminal value, `done` pulses, state goes to DONE.
- `dir`, `limit`, `prescale` and `auto_reload` are read live at each step. Changing `prescale` below the current prescaler value causes wrap at 2^PRE_W; software must stop or load first.

## Timing
- `start` sampled at edge E: `busy`=1 from E. The first step occurs at edge E+`prescale`+1, and subsequent steps every `prescale`+1 edges.
- With `prescale`=0, `count` steps every cycle in RUN.
- `tick` and `done` are registered and high for exactly the one cycle following the step edge.
- Pause latency:
  - `pause` high at edge E: no step at E or later; `paused`=1 from E.
  - `pause` low at edge E: RUN from E; the prescaler resumes from its frozen value.
- A command coincident with a step edge wins over the step: the step is discarded and `tick`/`done` stay 0.
- `rst` asserted mid-count forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, then `prescale`=3, `dir`=0, `limit`=5, `auto_reload`=0, pulse `start` → `count` steps 0→1→…→5 every 4 cycles; `done` pulses with 5; state DONE; `busy`=0.
- `auto_reload`=1, `dir`=1, `limit`=2, `prescale`=0, `start` → `count` sequence 2,1,0,2,1,0 (starting from a `load` of 2); `done` pulses each time 2 reappears after 0.
- `pause` high for 10 cycles mid-period (prescaler at 2 of 3) → no `tick` during HOLD; the first `tick` after release arrives 2 cycles later.
- `stop` and `start` asserted in the same cycle during RUN → IDLE; `count` unchanged; no `tick`.
- `load`=9 coincident with a step edge while `count`=4 → `count`=9, no `tick`; the next step arrives `prescale`+1 cycles later.
- Asynchronous `rst` pulse between edges during RUN with `count`=7 → `count`=0 and `busy`=0 before the next edge.
